// File: rtl/core_launcher_pkg.sv
// rtl/core_launcher_pkg.sv - shared types and constants for the core launcher
//
// Purpose: job-sequencer state encoding, HOLD length and default parameter values.
// Ports: none (package).
package core_launcher_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LOAD = 3'd1,
    ST_HOLD = 3'd2,
    ST_RUN  = 3'd3,
    ST_DONE = 3'd4,
    ST_TOUT = 3'd5
  } state_t;

  // Core reset stays asserted this many cycles after the load completes.
  localparam int HOLD_CYCLES = 2;

  localparam int DEF_AW      = 8;
  localparam int DEF_LEN     = 64;
  localparam int DEF_BASE    = 0;
  localparam int DEF_TIMEOUT = 4096;
  localparam int DEF_CW      = 16;

endpackage

// File: rtl/core_launcher_if.sv
// rtl/core_launcher_if.sv - byte-stream handshake bundle feeding the launcher
//
// Purpose: groups the source byte stream (valid/data/ready).
// Signals: in_valid (source byte valid), in_data[7:0] (byte), in_ready (launcher accepts).
// Modports: master = byte source, slave = launcher.
interface core_launcher_if;

  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;

  modport master (output in_valid, output in_data, input in_ready);
  modport slave  (input in_valid, input in_data, output in_ready);

endinterface

// File: rtl/core_launcher_run_timer.sv
// rtl/core_launcher_run_timer.sv - RUN-cycle counter with terminal-count compare
//
// Purpose: CW-bit counter with synchronous clear and enable.
// Ports: clk, reset (sync, active-high), clear, enable, count[CW-1:0],
//        tc (high when the next enabled increment reaches TIMEOUT).
module core_launcher_run_timer #(
  parameter int CW      = 16,
  parameter int TIMEOUT = 4096
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clear,
  input  logic          enable,
  output logic [CW-1:0] count,
  output logic          tc
);

  localparam logic [CW-1:0] TC_VAL = CW'(TIMEOUT - 1);

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + 1'b1;
    end
  end

  // Compared one short so the abort happens on the edge where count lands on TIMEOUT.
  assign tc = (count == TC_VAL);

endmodule

// File: rtl/core_launcher.sv
// rtl/core_launcher.sv - job sequencer: load data memory, pulse core, await done
//
// Purpose: accepts LEN bytes from src, writes them to data memory at BASE+index,
//          holds core reset for HOLD_CYCLES, pulses core_req, then waits for
//          core_done or TIMEOUT RUN cycles.
// Ports: clk, reset (sync, active-high), start, src (byte stream, slave),
//        mem_wr_en/mem_addr/mem_dat (data-memory write port), core_reset,
//        core_req, core_done, busy, finished, timeout, cycles, load_xor.
// Macro: CORE_LAUNCHER_CHECKSUM_EN enables the load_xor accumulator; otherwise 0.
module core_launcher
  import core_launcher_pkg::*;
#(
  parameter int AW      = DEF_AW,
  parameter int LEN     = DEF_LEN,
  parameter int BASE    = DEF_BASE,
  parameter int TIMEOUT = DEF_TIMEOUT,
  parameter int CW      = DEF_CW
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  core_launcher_if.slave         src,
  output logic                   mem_wr_en,
  output logic [AW-1:0]          mem_addr,
  output logic [7:0]             mem_dat,
  output logic                   core_reset,
  output logic                   core_req,
  input  logic                   core_done,
  output logic                   busy,
  output logic                   finished,
  output logic                   timeout,
  output logic [CW-1:0]          cycles,
  output logic [7:0]             load_xor
);

  // Index is one bit wider than the address so LEN = 2**AW is representable.
  localparam int            IW     = AW + 1;
  localparam logic [IW-1:0] LAST   = IW'(LEN - 1);
  localparam logic [AW-1:0] BASE_A = AW'(BASE);

  state_t        state_q, state_d;
  logic [IW-1:0] idx_q;
  logic [1:0]    hold_q;
  logic          in_ready;
  logic          accept;
  logic          start_ok;
  logic          run_tc;
  logic [CW-1:0] run_count;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      if (start_ok) begin
        idx_q <= '0;
      end else if (accept) begin
        idx_q <= idx_q + 1'b1;
      end
      hold_q <= (state_q == ST_HOLD) ? hold_q + 1'b1 : 2'd0;
    end
  end

  always_comb begin
    state_d    = state_q;
    in_ready   = 1'b0;
    mem_dat    = '0;
    accept     = 1'b0;
    start_ok   = 1'b0;
    core_reset = 1'b1;
    busy       = 1'b0;
    case (state_q)
      ST_IDLE, ST_TOUT: begin
        if (start) begin
          start_ok = 1'b1;
          state_d  = ST_LOAD;
        end
      end
      ST_LOAD: begin
        busy     = 1'b1;
        in_ready = 1'b1;
        mem_dat  = src.in_data;
        if (src.in_valid) begin
          accept = 1'b1;
          if (idx_q == LAST) state_d = ST_HOLD;
        end
      end
      ST_HOLD: begin
        busy = 1'b1;
        if (hold_q == 2'(HOLD_CYCLES - 1)) state_d = ST_RUN;
      end
      ST_RUN: begin
        busy       = 1'b1;
        core_reset = 1'b0;
        // done takes priority over the timeout in the same cycle
        if (core_done) begin
          state_d = ST_DONE;
        end else if (run_tc) begin
          state_d = ST_TOUT;
        end
      end
      ST_DONE: begin
        // core left out of reset so its state can be read back
        core_reset = 1'b0;
        if (start) begin
          start_ok = 1'b1;
          state_d  = ST_LOAD;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Count freezes outside RUN, so it already equals the latched result in DONE/TOUT.
  core_launcher_run_timer #(
    .CW      (CW),
    .TIMEOUT (TIMEOUT)
  ) u_run_timer (
    .clk    (clk),
    .reset  (reset),
    .clear  (start_ok),
    .enable ((state_q == ST_RUN) && !core_done),
    .count  (run_count),
    .tc     (run_tc)
  );

  assign src.in_ready = in_ready;
  assign mem_wr_en    = accept;
  assign mem_addr     = BASE_A + idx_q[AW-1:0];
  // count is zero in RUN only on the entry cycle, which gives the one-cycle request
  assign core_req     = (state_q == ST_RUN) && (run_count == '0);
  assign finished     = (state_q == ST_DONE);
  assign timeout      = (state_q == ST_TOUT);
  assign cycles       = run_count;

`ifdef CORE_LAUNCHER_CHECKSUM_EN
  logic [7:0] xor_q;

  always_ff @(posedge clk) begin
    if (reset || start_ok) begin
      xor_q <= '0;
    end else if (accept) begin
      xor_q <= xor_q ^ src.in_data;
    end
  end

  assign load_xor = xor_q;
`else
  assign load_xor = '0;
`endif

endmodule

// File: tb/tb_core_launcher.sv
// tb/tb_core_launcher.sv - directed self-checking bench for core_launcher
module tb_core_launcher;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  // u0: default parameters
  core_launcher_if a_if();
  logic        a_start, a_wr, a_creset, a_req, a_done, a_busy, a_fin, a_tout;
  logic [7:0]  a_addr, a_dat, a_xor;
  logic [15:0] a_cyc;

  // u1: wrapping address window and short timeout
  core_launcher_if b_if();
  logic        b_start, b_wr, b_creset, b_req, b_done, b_busy, b_fin, b_tout;
  logic [5:0]  b_addr;
  logic [7:0]  b_dat, b_xor;
  logic [15:0] b_cyc;

  core_launcher u0 (
    .clk(clk), .reset(reset), .start(a_start), .src(a_if),
    .mem_wr_en(a_wr), .mem_addr(a_addr), .mem_dat(a_dat),
    .core_reset(a_creset), .core_req(a_req), .core_done(a_done),
    .busy(a_busy), .finished(a_fin), .timeout(a_tout),
    .cycles(a_cyc), .load_xor(a_xor)
  );

  core_launcher #(.AW(6), .LEN(8), .BASE(60), .TIMEOUT(16), .CW(16)) u1 (
    .clk(clk), .reset(reset), .start(b_start), .src(b_if),
    .mem_wr_en(b_wr), .mem_addr(b_addr), .mem_dat(b_dat),
    .core_reset(b_creset), .core_req(b_req), .core_done(b_done),
    .busy(b_busy), .finished(b_fin), .timeout(b_tout),
    .cycles(b_cyc), .load_xor(b_xor)
  );

  int total = 0;
  int bad   = 0;
  int a_req_cnt = 0;
  logic [7:0] a_wa[$];
  logic [7:0] a_wd[$];
  logic [5:0] b_wa[$];
  logic [7:0] b_wd[$];

  // Write log sampled mid-cycle, away from the active edge.
  always @(negedge clk) begin
    if (a_wr) begin
      a_wa.push_back(a_addr);
      a_wd.push_back(a_dat);
    end
    if (b_wr) begin
      b_wa.push_back(b_addr);
      b_wd.push_back(b_dat);
    end
    if (a_req) a_req_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int errs;
    logic [7:0] exp_xor;
    reset = 1'b1;
    a_start = 0; a_done = 0; a_if.in_valid = 0; a_if.in_data = 0;
    b_start = 0; b_done = 0; b_if.in_valid = 0; b_if.in_data = 0;
    tick(); tick(); tick();

    // Reset state
    check("rst_busy",   a_busy,   0);
    check("rst_creset", a_creset, 1);
    check("rst_req",    a_req,    0);
    check("rst_ready",  a_if.in_ready, 0);
    check("rst_wr",     a_wr,     0);
    check("rst_addr",   a_addr,   0);
    check("rst_dat",    a_dat,    0);
    check("rst_fin",    a_fin,    0);
    check("rst_tout",   a_tout,   0);
    check("rst_cyc",    a_cyc,    0);
    check("rst_xor",    a_xor,    0);
    check("rst_addr_b", b_addr,   60);

    // Reset in the middle of a load after 10 beats
    reset = 1'b0;
    a_start = 1; tick(); a_start = 0;
    check("load_ready", a_if.in_ready, 1);
    check("load_busy",  a_busy, 1);
    for (int i = 0; i < 10; i++) begin
      a_if.in_valid = 1; a_if.in_data = 8'(i); tick();
    end
    a_if.in_valid = 0;
    reset = 1'b1; tick();
    a_if.in_valid = 1;
    check("midrst_wr",     a_wr,     0);
    check("midrst_creset", a_creset, 1);
    check("midrst_busy",   a_busy,   0);
    check("midrst_ready",  a_if.in_ready, 0);
    check("midrst_addr",   a_addr,   0);
    check("midrst_dat",    a_dat,    0);
    tick();
    check("midrst_wr2",    a_wr,     0);
    a_if.in_valid = 0; reset = 1'b0;
    tick();
    check("midrst_nwr",    a_wa.size(), 10);
    a_wa.delete(); a_wd.delete(); a_req_cnt = 0;

    // Full-rate load of 64 bytes
    a_start = 1; tick(); a_start = 0;
    for (int i = 0; i < 64; i++) begin
      a_if.in_valid = 1; a_if.in_data = 8'(i * 3 + 1); tick();
    end
    a_if.in_valid = 0;
    check("full_nwr", a_wa.size(), 64);
    errs = 0;
    foreach (a_wa[k]) begin
      if (a_wa[k] !== 8'(k) || a_wd[k] !== 8'(k * 3 + 1)) errs++;
    end
    check("full_contents", errs, 0);
    check("hold1_ready",  a_if.in_ready, 0);
    check("hold1_creset", a_creset, 1);
    check("hold1_busy",   a_busy, 1);
    check("hold1_req",    a_req, 0);
    tick();
    check("hold2_creset", a_creset, 1);
    check("hold2_req",    a_req, 0);
    tick();
    check("run0_creset",  a_creset, 0);
    check("run0_req",     a_req, 1);

    // Done 37 cycles after RUN entry
    for (int i = 0; i < 37; i++) tick();
    check("run37_busy", a_busy, 1);
    a_done = 1; tick(); a_done = 0;
    check("done_reqcnt", a_req_cnt, 1);
    check("done_fin",    a_fin, 1);
    check("done_tout",   a_tout, 0);
    check("done_cyc",    a_cyc, 37);
    check("done_busy",   a_busy, 0);
    check("done_creset", a_creset, 0);
    for (int i = 0; i < 4; i++) tick();
    a_start = 1; tick(); a_start = 0;
    check("restart_fin",  a_fin, 0);
    check("restart_cyc",  a_cyc, 0);
    check("restart_busy", a_busy, 1);

    // Load with bubbles on alternate cycles
    a_wa.delete(); a_wd.delete();
    for (int i = 0; i < 128; i++) begin
      a_if.in_valid = (i % 2 == 0);
      a_if.in_data  = 8'(i / 2);
      tick();
    end
    a_if.in_valid = 0;
    check("bub_nwr", a_wa.size(), 64);
    errs = 0;
    foreach (a_wa[k]) begin
      if (a_wa[k] !== 8'(k) || a_wd[k] !== 8'(k)) errs++;
    end
    check("bub_contents", errs, 0);
    check("bub_hold2_creset", a_creset, 1);
    tick();
    check("bub_run0_req", a_req, 1);
    // Done in the very first RUN cycle
    a_done = 1; tick(); a_done = 0;
    check("done0_fin", a_fin, 1);
    check("done0_cyc", a_cyc, 0);

    // u1: address wrap, checksum, timeout
    b_start = 1; tick(); b_start = 0;
    b_wa.delete(); b_wd.delete();
    for (int i = 0; i < 8; i++) begin
      b_if.in_valid = 1; b_if.in_data = 8'(i + 1); tick();
    end
    b_if.in_valid = 0;
    check("wrap_nwr", b_wa.size(), 8);
    errs = 0;
    foreach (b_wa[k]) begin
      if (b_wa[k] !== 6'((60 + k) % 64) || b_wd[k] !== 8'(k + 1)) errs++;
    end
    check("wrap_contents", errs, 0);
`ifdef CORE_LAUNCHER_CHECKSUM_EN
    exp_xor = 8'h08;
`else
    exp_xor = 8'h00;
`endif
    check("wrap_xor", b_xor, exp_xor);
    tick(); tick();
    check("b_run0_req", b_req, 1);
    for (int i = 0; i < 15; i++) tick();
    check("b_run15_busy", b_busy, 1);
    tick();
    check("tout_flag",   b_tout, 1);
    check("tout_fin",    b_fin, 0);
    check("tout_cyc",    b_cyc, 16);
    check("tout_creset", b_creset, 1);
    check("tout_busy",   b_busy, 0);
    b_done = 1; tick(); b_done = 0; tick();
    check("tout_hold_flag", b_tout, 1);
    check("tout_hold_fin",  b_fin, 0);
    check("tout_hold_cyc",  b_cyc, 16);
    check("tout_hold_xor",  b_xor, exp_xor);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
